fp_to_bcd: RTL

- Sits directly downstream of the 12-bit-to-floating-point converter (fpcvt).
- Consumes its sign/exponent/significand triple and reconstructs the represented value (f << e, negated when s=1).
- Converts the magnitude to four BCD digits with a sequential double-dabble, one bit per cycle.
- Results go to the display/readout logic through a valid/ready handshake.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/dabble_step.sv | 24 ++
 rtl/fp_to_bcd.sv | 90 +++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and state encoding for the fp_to_bcd readout path.
//   E_W/F_W   : exponent / significand widths of the fpcvt triple
//   MAG_W     : reconstructed magnitude width (15 << 7 = 1920 fits in 11 bits)
//   DIGITS    : BCD digits produced, BCD_W = 4*DIGITS
//   SR_W      : double-dabble shift register width {BCD, magnitude}
//   VALUE_W   : signed result width, derived from the largest magnitude
package fp_pkg;

  localparam int unsigned E_W     = 3;
  localparam int unsigned F_W     = 4;
  localparam int unsigned MAG_W   = 11;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned SR_W    = BCD_W + MAG_W;
  localparam int unsigned MAX_MAG = 1920;
  localparam int unsigned VALUE_W = $clog2(MAX_MAG + 1) + 1;
  localparam int unsigned CNT_W   = $clog2(MAG_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/dabble_step.sv
// dabble_step: one combinational double-dabble iteration.
//   din  : {BCD digits, remaining magnitude bits}, SR_W bits
//   dout : every BCD nibble >= 5 corrected by +3, then the whole word
//          shifted left by one bit
module dabble_step
  import fp_pkg::*;
(
  input  logic [SR_W-1:0] din,
  output logic [SR_W-1:0] dout
);

  logic [SR_W-1:0] work;

  always_comb begin
    work = din;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work[MAG_W + 4*i +: 4] >= 4'd5) begin
        work[MAG_W + 4*i +: 4] = work[MAG_W + 4*i +: 4] + 4'd3;
      end
    end
    dout = work << 1;
  end

endmodule

// File: rtl/fp_to_bcd.sv
// fp_to_bcd: rebuilds the value carried by an fpcvt {sign, exponent,
// significand} triple (f << e, negated when s=1) and converts its magnitude
// to four BCD digits with a sequential double-dabble, one bit per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : upstream handshake for s_in / e_in / f_in
//   out_valid/out_ready : downstream handshake for neg / value / bcd
//   neg                 : result negative (never set for zero magnitude)
//   value               : 12-bit two's-complement reconstructed value
//   bcd                 : thousands in [15:12] ... units in [3:0]
module fp_to_bcd
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               s_in,
  input  logic [E_W-1:0]     e_in,
  input  logic [F_W-1:0]     f_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               neg,
  output logic [VALUE_W-1:0] value,
  output logic [BCD_W-1:0]   bcd
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    step_out;
  logic [MAG_W-1:0]   mag_in;
  logic [MAG_W-1:0]   mag_r;
  logic               neg_r;
  logic [VALUE_W-1:0] mag_ext;

  assign mag_in    = MAG_W'(f_in) << e_in;
  assign mag_ext   = VALUE_W'(mag_r);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  dabble_step u_step (
    .din  (sr),
    .dout (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      mag_r <= '0;
      neg_r <= 1'b0;
      neg   <= 1'b0;
      value <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_r <= mag_in;
            // a zero magnitude is never reported as negative
            neg_r <= s_in & (|mag_in);
            sr    <= {{BCD_W{1'b0}}, mag_in};
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= step_out;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MAG_W - 1)) begin
            // outputs are taken from the final step directly so they are
            // valid in the same cycle that out_valid rises
            bcd   <= step_out[SR_W-1 -: BCD_W];
            neg   <= neg_r;
            value <= neg_r ? (-mag_ext) : mag_ext;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
